// File: rtl/vortex_dcr_seq_pkg.sv
// Shared types and default widths for the multi-device DCR/launch sequencer.
package vortex_dcr_seq_pkg;

  localparam int VX_DCR_ADDR_WIDTH = 12;
  localparam int VX_DCR_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_BUSY,
    ST_RUN
  } seq_state_e;

endpackage

// File: rtl/VX_fifo_queue.sv
// Registered-output-free circular FIFO; head entry is readable while not empty.
module VX_fifo_queue #(
  parameter int DATAW = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [DATAW-1:0] data_in,
  output logic [DATAW-1:0] data_out,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [DATAW-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [AW:0]      count;

  // Callers gate push with !full and pop with !empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  assign data_out = mem[rd_ptr];
  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/vortex_dcr_sequencer.sv
// Buffers host DCR writes, broadcasts them to idle devices, and sequences
// masked kernel launches with run/done status and a run cycle count.
module vortex_dcr_sequencer
  import vortex_dcr_seq_pkg::*;
#(
  parameter int NUM_DEVICES    = 2,
  parameter int DCR_ADDR_WIDTH = VX_DCR_ADDR_WIDTH,
  parameter int DCR_DATA_WIDTH = VX_DCR_DATA_WIDTH,
  parameter int FIFO_DEPTH     = 4,
  parameter int BUSY_TIMEOUT   = 16,
  parameter int CYCLE_WIDTH    = 48
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      host_dcr_valid,
  output logic                      host_dcr_ready,
  input  logic [DCR_ADDR_WIDTH-1:0] host_dcr_addr,
  input  logic [DCR_DATA_WIDTH-1:0] host_dcr_data,
  input  logic [NUM_DEVICES-1:0]    host_dcr_mask,
  input  logic                      host_start_valid,
  output logic                      host_start_ready,
  input  logic [NUM_DEVICES-1:0]    host_start_mask,
  output logic [NUM_DEVICES-1:0]    dev_dcr_wr_valid,
  output logic [DCR_ADDR_WIDTH-1:0] dev_dcr_wr_addr,
  output logic [DCR_DATA_WIDTH-1:0] dev_dcr_wr_data,
  output logic [NUM_DEVICES-1:0]    dev_start,
  input  logic [NUM_DEVICES-1:0]    dev_busy,
  output logic                      busy,
  output logic                      done,
  output logic [CYCLE_WIDTH-1:0]    run_cycles
);
  localparam int TMO_W = $clog2(BUSY_TIMEOUT + 1);

  typedef struct packed {
    logic [NUM_DEVICES-1:0]    mask;
    logic [DCR_ADDR_WIDTH-1:0] addr;
    logic [DCR_DATA_WIDTH-1:0] data;
  } dcr_entry_t;

  seq_state_e             state, state_nxt;
  logic [NUM_DEVICES-1:0] run_mask, seen, seen_nxt, busy_masked;
  logic [TMO_W-1:0]       tmo_cnt;
  dcr_entry_t             push_entry, pop_entry;
  logic                   fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic                   start_acc, tmo_hit;

  assign push_entry       = '{mask: host_dcr_mask, addr: host_dcr_addr, data: host_dcr_data};
  assign fifo_push        = host_dcr_valid && !fifo_full;
  assign host_dcr_ready   = !fifo_full;
  assign host_start_ready = (state == ST_IDLE) && fifo_empty;
  assign start_acc        = host_start_valid && host_start_ready;
  assign busy             = (state != ST_IDLE);
  assign busy_masked      = dev_busy & run_mask;
  assign tmo_hit          = (tmo_cnt == TMO_W'(BUSY_TIMEOUT - 1));

  VX_fifo_queue #(
    .DATAW (NUM_DEVICES + DCR_ADDR_WIDTH + DCR_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) dcr_fifo (
    .clk      (clk),
    .rst_n    (reset),
    .push     (fifo_push),
    .pop      (fifo_pop),
    .data_in  (push_entry),
    .data_out (pop_entry),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  always_comb begin
    state_nxt = state;
    seen_nxt  = seen;
    fifo_pop  = 1'b0;
    case (state)
      ST_IDLE: begin
        // Draining only here keeps DCR writes away from running devices.
        fifo_pop = !fifo_empty;
        if (start_acc) state_nxt = ST_LAUNCH;
      end
      ST_LAUNCH:
        state_nxt = (run_mask == '0) ? ST_IDLE : ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        seen_nxt = seen | busy_masked;
        if (seen_nxt == run_mask || tmo_hit) state_nxt = ST_RUN;
      end
      ST_RUN:
        if (busy_masked == '0) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= ST_IDLE;
      run_mask         <= '0;
      seen             <= '0;
      tmo_cnt          <= '0;
      run_cycles       <= '0;
      done             <= 1'b0;
      dev_start        <= '0;
      dev_dcr_wr_valid <= '0;
      dev_dcr_wr_addr  <= '0;
      dev_dcr_wr_data  <= '0;
    end else begin
      state     <= state_nxt;
      seen      <= start_acc ? '0 : seen_nxt;
      tmo_cnt   <= (state == ST_WAIT_BUSY) ? tmo_cnt + TMO_W'(1) : '0;
      dev_start <= start_acc ? host_start_mask : '0;
      if (start_acc) begin
        run_mask   <= host_start_mask;
        run_cycles <= '0;
        done       <= 1'b0;
      end else begin
        if ((state == ST_WAIT_BUSY || state == ST_RUN) && !(&run_cycles))
          run_cycles <= run_cycles + CYCLE_WIDTH'(1);
        if ((state == ST_LAUNCH && run_mask == '0) ||
            (state == ST_RUN && busy_masked == '0))
          done <= 1'b1;
      end
      // A zero-mask entry pops with no strobe.
      dev_dcr_wr_valid <= fifo_pop ? pop_entry.mask : '0;
      if (fifo_pop) begin
        dev_dcr_wr_addr <= pop_entry.addr;
        dev_dcr_wr_data <= pop_entry.data;
      end
    end
  end

endmodule

// File: tb/tb_vortex_dcr_sequencer.sv
// Randomized bench for vortex_dcr_sequencer with a device model and a
// strobe scoreboard derived from host-side pushes.
module tb_vortex_dcr_sequencer;
  localparam int ND = 2, AW = 12, DW = 32, FD = 4, BT = 16, CW = 48;

  logic          clk = 1'b0;
  logic          reset;
  logic          host_dcr_valid = 1'b0, host_dcr_ready;
  logic [AW-1:0] host_dcr_addr = '0;
  logic [DW-1:0] host_dcr_data = '0;
  logic [ND-1:0] host_dcr_mask = '0;
  logic          host_start_valid = 1'b0, host_start_ready;
  logic [ND-1:0] host_start_mask = '0;
  logic [ND-1:0] dev_dcr_wr_valid, dev_start;
  logic [AW-1:0] dev_dcr_wr_addr;
  logic [DW-1:0] dev_dcr_wr_data;
  logic [ND-1:0] dev_busy = '0;
  logic          busy, done;
  logic [CW-1:0] run_cycles;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [ND-1:0] mask;
  } ent_t;

  ent_t exp_q[$];
  int   checks = 0, errors = 0, strobe_cnt = 0;
  int   dur[ND]  = '{default: 0};
  int   bcnt[ND] = '{default: 0};
  bit   dev_kill = 1'b0;

  vortex_dcr_sequencer #(
    .NUM_DEVICES(ND), .DCR_ADDR_WIDTH(AW), .DCR_DATA_WIDTH(DW),
    .FIFO_DEPTH(FD), .BUSY_TIMEOUT(BT), .CYCLE_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .host_dcr_valid(host_dcr_valid), .host_dcr_ready(host_dcr_ready),
    .host_dcr_addr(host_dcr_addr), .host_dcr_data(host_dcr_data),
    .host_dcr_mask(host_dcr_mask),
    .host_start_valid(host_start_valid), .host_start_ready(host_start_ready),
    .host_start_mask(host_start_mask),
    .dev_dcr_wr_valid(dev_dcr_wr_valid), .dev_dcr_wr_addr(dev_dcr_wr_addr),
    .dev_dcr_wr_data(dev_dcr_wr_data), .dev_start(dev_start),
    .dev_busy(dev_busy), .busy(busy), .done(done), .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  // Device model: a started device stays busy for dur[i] cycles.
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < ND; i++) begin
      if (dev_kill) bcnt[i] = 0;
      else if (dev_start[i] && dur[i] > 0) bcnt[i] = dur[i];
      else if (bcnt[i] > 0) bcnt[i]--;
      dev_busy[i] = (bcnt[i] != 0);
    end
  end

  // Every strobe must match the oldest accepted non-zero-mask push.
  always @(negedge clk) begin
    ent_t e;
    if (reset === 1'b1 && |dev_dcr_wr_valid) begin
      checks++;
      strobe_cnt++;
      if (busy) begin
        errors++;
        $display("FAIL strobe_in_run valid=%b", dev_dcr_wr_valid);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe valid=%b addr=%h", dev_dcr_wr_valid, dev_dcr_wr_addr);
      end else begin
        e = exp_q.pop_front();
        if (dev_dcr_wr_valid !== e.mask || dev_dcr_wr_addr !== e.addr || dev_dcr_wr_data !== e.data) begin
          errors++;
          $display("FAIL strobe_content got %b/%h/%h want %b/%h/%h", dev_dcr_wr_valid,
                   dev_dcr_wr_addr, dev_dcr_wr_data, e.mask, e.addr, e.data);
        end
      end
    end
  end

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [ND-1:0] m, output bit acc);
    host_dcr_valid = 1'b1; host_dcr_addr = a; host_dcr_data = d; host_dcr_mask = m;
    acc = host_dcr_ready;
    if (acc && m != '0) exp_q.push_back('{a, d, m});
    @(negedge clk);
    host_dcr_valid = 1'b0;
  endtask

  task automatic do_start(input logic [ND-1:0] m);
    host_start_valid = 1'b1; host_start_mask = m;
    checks++;
    if (host_start_ready !== 1'b1) begin
      errors++; $display("FAIL start_ready got %b want 1", host_start_ready);
    end
    @(negedge clk);
    host_start_valid = 1'b0;
    checks++;
    if (dev_start !== m || busy !== 1'b1 || done !== 1'b0 || run_cycles !== '0) begin
      errors++;
      $display("FAIL launch dev_start=%b busy=%b done=%b cyc=%0d want %b/1/0/0",
               dev_start, busy, done, run_cycles, m);
    end
    @(negedge clk);
    checks++;
    if (dev_start !== '0) begin
      errors++; $display("FAIL start_pulse_width dev_start=%b want 0", dev_start);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (host_dcr_ready !== 1'b1 || host_start_ready !== 1'b1 || busy !== 1'b0 ||
        done !== 1'b0 || run_cycles !== '0 || dev_start !== '0 || dev_dcr_wr_valid !== '0 ||
        dev_dcr_wr_addr !== '0 || dev_dcr_wr_data !== '0) begin
      errors++;
      $display("FAIL reset_values rdy=%b srdy=%b busy=%b done=%b cyc=%0d start=%b wr=%b",
               host_dcr_ready, host_start_ready, busy, done, run_cycles, dev_start, dev_dcr_wr_valid);
    end
  endtask

  task automatic test_dcr_latency();
    bit acc;
    push(12'h001, 32'hDEAD_BEEF, 2'b10, acc);
    checks++;
    if (!acc || dev_dcr_wr_valid !== '0) begin
      errors++; $display("FAIL dcr_early acc=%b valid=%b want 1/00", acc, dev_dcr_wr_valid);
    end
    @(negedge clk);
    checks++;
    if (dev_dcr_wr_valid !== 2'b10 || dev_dcr_wr_addr !== 12'h001 || dev_dcr_wr_data !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL dcr_latency got %b/%h/%h want 10/001/deadbeef", dev_dcr_wr_valid,
               dev_dcr_wr_addr, dev_dcr_wr_data);
    end
    @(negedge clk);
    checks++;
    if (dev_dcr_wr_valid !== '0) begin
      errors++; $display("FAIL dcr_pulse_width valid=%b want 00", dev_dcr_wr_valid);
    end
  endtask

  task automatic test_back_to_back();
    bit acc;
    int want = 0, base = strobe_cnt, n = 0;
    logic [ND-1:0] m;
    for (int i = 0; i < 6; i++) begin
      m = ND'($urandom_range(0, 3));
      push(AW'($urandom), $urandom, m, acc);
      if (acc && m != '0) want++;
    end
    while (exp_q.size() != 0 && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || strobe_cnt - base != want) begin
      errors++;
      $display("FAIL back_to_back strobes=%0d want %0d pending=%0d", strobe_cnt - base, want, exp_q.size());
    end
  endtask

  task automatic test_run(input logic [ND-1:0] m, input int d0, input int d1);
    int  longest, n = 0;
    bit  got = 0, cur, prev, prev2;
    dur[0] = d0; dur[1] = d1;
    longest = 0;
    if (m[0] && d0 > longest) longest = d0;
    if (m[1] && d1 > longest) longest = d1;
    do_start(m);
    prev = (dev_busy & m) != '0; prev2 = prev;
    // done must appear exactly one cycle after masked busy is first seen low.
    while (n < 200 && !got) begin
      @(negedge clk); n++;
      cur = (dev_busy & m) != '0;
      if (done) begin
        got = 1;
        checks++;
        if (cur || prev || !prev2) begin
          errors++; $display("FAIL done_timing mask=%b d=%0d/%0d after %0d cycles", m, d0, d1, n);
        end
      end
      prev2 = prev; prev = cur;
    end
    checks++;
    if (!got || run_cycles < CW'(longest - 1) || run_cycles > CW'(longest + 2) || busy !== 1'b0) begin
      errors++;
      $display("FAIL run_cycles got=%0d want %0d..%0d done=%b busy=%b", run_cycles,
               longest - 1, longest + 2, got, busy);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    bit early = 0;
    dur[0] = 0; dur[1] = 0;
    do_start(2'b01);
    while (n < 100 && !done) begin
      @(negedge clk); n++;
      if (n == 10 && done) early = 1;
    end
    checks++;
    if (!done || early || n < BT - 2 || n > BT + 3) begin
      errors++; $display("FAIL timeout_done got %0d cycles done=%b want %0d..%0d", n, done, BT - 2, BT + 3);
    end
    checks++;
    if (run_cycles < CW'(BT) || run_cycles > CW'(BT + 2)) begin
      errors++; $display("FAIL timeout_cycles got=%0d want %0d..%0d", run_cycles, BT, BT + 2);
    end
  endtask

  task automatic test_zero_mask();
    do_start('0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || run_cycles !== '0) begin
      errors++; $display("FAIL zero_mask done=%b busy=%b cyc=%0d want 1/0/0", done, busy, run_cycles);
    end
  endtask

  task automatic test_backpressure();
    bit acc;
    int n = 0;
    dur[0] = 30; dur[1] = 30;
    do_start(2'b11);
    for (int i = 0; i < 5; i++) begin
      push(AW'($urandom), $urandom, ND'($urandom_range(1, 3)), acc);
      checks++;
      if (acc !== (i < FD)) begin
        errors++; $display("FAIL fifo_ready push%0d accepted=%b want %b", i, acc, i < FD);
      end
    end
    while (n < 100 && !done) begin @(negedge clk); n++; end
    checks++;
    if (!done || exp_q.size() != FD) begin
      errors++; $display("FAIL held_entries done=%b pending=%0d want 1/%0d", done, exp_q.size(), FD);
    end
    for (int i = 0; i < FD; i++) begin
      @(negedge clk);
      checks++;
      if (dev_dcr_wr_valid === '0) begin
        errors++; $display("FAIL drain_consecutive slot%0d valid=%b want nonzero", i, dev_dcr_wr_valid);
      end
    end
    @(negedge clk);
    checks++;
    if (dev_dcr_wr_valid !== '0 || exp_q.size() != 0) begin
      errors++; $display("FAIL drain_end valid=%b pending=%0d", dev_dcr_wr_valid, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_run();
    bit acc;
    dur[0] = 40; dur[1] = 40;
    do_start(2'b11);
    push(12'h0AA, 32'h1234_5678, 2'b01, acc);
    push(12'h0BB, 32'h8765_4321, 2'b11, acc);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    test_reset();
    exp_q.delete();
    dev_kill = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (host_start_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL post_reset srdy=%b busy=%b done=%b want 1/0/0", host_start_ready, busy, done);
    end
    dev_kill = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b1;
    @(negedge clk);
    test_dcr_latency();
    test_back_to_back();
    test_run(2'b11, 10, 20);
    for (int i = 0; i < 4; i++)
      test_run(ND'($urandom_range(1, 3)), $urandom_range(2, 30), $urandom_range(2, 30));
    test_timeout();
    test_zero_mask();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL final_pending got %0d want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
